// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode hazard controller: FSM encoding, scoreboard slot
// layout and the register-match helper used by the scoreboard comparators.
package hazard_ctrl_pkg;

  localparam int PIPE_DEPTH_DEFAULT = 3;

  typedef logic [1:0] hz_state_t;

  localparam hz_state_t HZ_RUN     = 2'd0;
  localparam hz_state_t HZ_MEMWAIT = 2'd1;
  localparam hz_state_t HZ_TRAP    = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } sb_slot_t;

  // x0 is hardwired to zero, so it can never be a true dependency.
  function automatic logic rs_hit(logic [4:0] rs, logic used, logic [4:0] rd);
    return used && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/sequencing bundle between the core pipeline (master) and hazard_ctrl (slave).
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic       id_rs1_used;
  logic [4:0] id_rs2_addr;
  logic       id_rs2_used;
  logic [4:0] id_rd_addr;
  logic       id_rf_wen;
  logic       id_is_load;
  logic       id_is_ecall;
  logic       ex_jmp_taken;
  logic       mem_busy;
  logic       trap_done;
  logic       stall_flg;
  logic       id_bubble;
  logic       flush;
  logic       pipe_hold;
  hz_state_t  state;

  modport master (
    output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
           id_rd_addr, id_rf_wen, id_is_load, id_is_ecall,
           ex_jmp_taken, mem_busy, trap_done,
    input  stall_flg, id_bubble, flush, pipe_hold, state
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
           id_rd_addr, id_rf_wen, id_is_load, id_is_ecall,
           ex_jmp_taken, mem_busy, trap_done,
    output stall_flg, id_bubble, flush, pipe_hold, state
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard (slot 0 youngest) with per-slot rs1/rs2 comparators.
// With HAZARD_FWD_EN defined only a load-use hit in slot 0 is reported; the rest is forwarded.
module hazard_scoreboard import hazard_ctrl_pkg::*; #(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_i,
  input  logic                  issue_i,
  input  logic [4:0]            rd_i,
  input  logic                  load_i,
  input  logic [4:0]            rs1_i,
  input  logic                  rs1_used_i,
  input  logic [4:0]            rs2_i,
  input  logic                  rs2_used_i,
  output logic [PIPE_DEPTH-1:0] match_o
);

  sb_slot_t [PIPE_DEPTH-1:0] slot_q, slot_d;
  sb_slot_t                  new_slot;
  logic     [PIPE_DEPTH-1:0] raw;

  assign new_slot = issue_i ? {1'b1, rd_i, load_i} : '0;

  // Slots only advance when the back end advances; a hold freezes them in place.
  always_comb begin
    slot_d = slot_q;
    if (shift_i) begin
      for (int k = PIPE_DEPTH-1; k > 0; k--) slot_d[k] = slot_q[k-1];
      slot_d[0] = new_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_cmp
    assign raw[k] = slot_q[k].valid &&
                    (rs_hit(rs1_i, rs1_used_i, slot_q[k].rd) ||
                     rs_hit(rs2_i, rs2_used_i, slot_q[k].rd));
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    match_o    = '0;
    match_o[0] = raw[0] & slot_q[0].load;
  end
`else
  logic unused_load;
  assign unused_load = slot_q[PIPE_DEPTH-1].load;
  assign match_o     = raw;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Decode hazard/sequencing controller: RAW interlock, jump flush, memory hold, ecall trap park.
// Forwarding behaviour (HAZARD_FWD_EN) lives entirely in hazard_scoreboard's match vector.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  hz_state_t             state_q, state_d;
  logic                  trap_pend_q, trap_pend_d;
  logic                  stall, bubble, flush, hold, issue, hazard;
  logic [PIPE_DEPTH-1:0] match;

  assign hazard = hz.id_valid & (|match);

  // MEMWAIT differs from RUN only while mem_busy stays high, so both share the RUN path.
  always_comb begin
    state_d     = state_q;
    trap_pend_d = trap_pend_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    hold        = 1'b0;
    if (state_q == HZ_TRAP) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (hz.mem_busy) begin
        hold        = 1'b1;
        trap_pend_d = trap_pend_q | hz.trap_done;
      end else if (hz.trap_done | trap_pend_q) begin
        flush       = 1'b1;
        trap_pend_d = 1'b0;
        state_d     = HZ_RUN;
      end
    end else if (hz.mem_busy) begin
      hold    = 1'b1;
      stall   = 1'b1;
      state_d = HZ_MEMWAIT;
    end else begin
      state_d = HZ_RUN;
      if (hz.ex_jmp_taken) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else if (hz.id_valid & hz.id_is_ecall) begin
        state_d = HZ_TRAP;
      end
    end
  end

  assign issue = hz.id_valid & ~stall & ~flush & hz.id_rf_wen & (hz.id_rd_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      trap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trap_pend_q <= trap_pend_d;
    end
  end

  hazard_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_i    (~hold),
    .issue_i    (issue),
    .rd_i       (hz.id_rd_addr),
    .load_i     (hz.id_is_load),
    .rs1_i      (hz.id_rs1_addr),
    .rs1_used_i (hz.id_rs1_used),
    .rs2_i      (hz.id_rs2_addr),
    .rs2_used_i (hz.id_rs2_used),
    .match_o    (match)
  );

  // Outputs follow live inputs, so they are forced low while reset is held.
  assign hz.stall_flg = rst_n & stall;
  assign hz.id_bubble = rst_n & bubble;
  assign hz.flush     = rst_n & flush;
  assign hz.pipe_hold = rst_n & hold;
  assign hz.state     = rst_n ? state_q : HZ_RUN;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle stimulus tables, expected outputs queued at drive
// time and popped at the following falling edge. Expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       rn, v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen, ld, ec, jmp, mb, td;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();
  hazard_ctrl #(.PIPE_DEPTH(3)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  int        checks = 0;
  int        passed = 0;
  logic [5:0] exp_q[$];
  stim_t      st_tab[$];
  logic [5:0] ex_tab[$];

  function automatic logic [5:0] E(logic s, logic b, logic f, logic h, logic [1:0] q);
    return {s, b, f, h, q};
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s    = '0;
    s.rn = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(logic [4:0] rd, logic [4:0] r1, logic u1,
                                logic [4:0] r2, logic u2, logic ld);
    stim_t s;
    s = nop();
    s.v = 1'b1; s.wen = 1'b1; s.rd = rd; s.ld = ld;
    s.rs1 = r1; s.u1 = u1; s.rs2 = r2; s.u2 = u2;
    return s;
  endfunction

  function automatic stim_t ecall_i();
    stim_t s;
    s = nop();
    s.v  = 1'b1;
    s.ec = 1'b1;
    return s;
  endfunction

  function automatic stim_t ctl(stim_t b, logic j, logic mb, logic td, logic rn);
    stim_t s;
    s = b; s.jmp = j; s.mb = mb; s.td = td; s.rn = rn;
    return s;
  endfunction

  function automatic logic [5:0] obs();
    return {hz.stall_flg, hz.id_bubble, hz.flush, hz.pipe_hold, hz.state};
  endfunction

  task automatic apply(input stim_t s);
    rst_n           = s.rn;
    hz.id_valid     = s.v;
    hz.id_rs1_addr  = s.rs1;
    hz.id_rs1_used  = s.u1;
    hz.id_rs2_addr  = s.rs2;
    hz.id_rs2_used  = s.u2;
    hz.id_rd_addr   = s.rd;
    hz.id_rf_wen    = s.wen;
    hz.id_is_load   = s.ld;
    hz.id_is_ecall  = s.ec;
    hz.ex_jmp_taken = s.jmp;
    hz.mem_busy     = s.mb;
    hz.trap_done    = s.td;
  endtask

  task automatic row(input stim_t s, input logic [5:0] e);
    st_tab.push_back(s);
    ex_tab.push_back(e);
  endtask

  task automatic drain();
    repeat (3) row(nop(), E(0, 0, 0, 0, HZ_RUN));
  endtask

  localparam logic [5:0] E0  = 6'b0;
  localparam logic [5:0] STL = 6'b110000;

  task automatic test_reset();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ctl(nop(), 1, 1, 1, 0), E0);
    row(ctl(ecall_i(), 0, 0, 0, 0), E0);
    row(nop(), E0);
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ins(5, 0, 1, 0, 0, 0), E0);
    repeat (3) row(ins(6, 5, 1, 0, 1, 0), FWD ? E0 : STL);
    row(ins(6, 5, 1, 0, 1, 0), E0);
    drain();
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL raw[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ins(7, 2, 1, 0, 0, 1), E0);
    row(ins(8, 7, 1, 1, 1, 0), STL);
    repeat (2) row(ins(8, 7, 1, 1, 1, 0), FWD ? E0 : STL);
    row(ins(8, 7, 1, 1, 1, 0), E0);
    drain();
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_unused();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ins(0, 0, 1, 0, 0, 0), E0);
    row(ins(1, 0, 1, 0, 1, 0), E0);
    row(ins(2, 0, 0, 0, 0, 0), E0);
    row(ins(1, 2, 0, 2, 0, 0), E0);
    drain();
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL x0_unused[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ins(5, 0, 1, 0, 0, 0), E0);
    row(ctl(ins(6, 5, 1, 0, 1, 0), 1, 0, 0, 1), E(0, 1, 1, 0, HZ_RUN));
    row(ins(9, 6, 1, 0, 1, 0), E0);
    drain();
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL jump[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_hold();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ins(5, 0, 1, 0, 0, 0), E0);
    row(ctl(nop(), 1, 1, 0, 1), E(1, 0, 0, 1, HZ_RUN));
    repeat (3) row(ctl(nop(), 1, 1, 0, 1), E(1, 0, 0, 1, HZ_MEMWAIT));
    row(ctl(nop(), 1, 0, 0, 1), E(0, 1, 1, 0, HZ_MEMWAIT));
    repeat (2) row(ins(6, 5, 1, 0, 1, 0), FWD ? E0 : STL);
    row(ins(6, 5, 1, 0, 1, 0), E0);
    drain();
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL mem_hold[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ecall_i(), E0);
    repeat (5) row(nop(), E(1, 1, 0, 0, HZ_TRAP));
    row(ctl(nop(), 0, 0, 1, 1), E(1, 1, 1, 0, HZ_TRAP));
    row(nop(), E0);
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL trap[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap_hold();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ecall_i(), E0);
    row(ctl(nop(), 0, 1, 0, 1), E(1, 1, 0, 1, HZ_TRAP));
    row(ctl(nop(), 0, 1, 1, 1), E(1, 1, 0, 1, HZ_TRAP));
    row(nop(), E(1, 1, 1, 0, HZ_TRAP));
    row(nop(), E0);
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL trap_hold[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    logic [5:0] got, want;
    st_tab.delete(); ex_tab.delete();
    row(ecall_i(), E0);
    row(nop(), E(1, 1, 0, 0, HZ_TRAP));
    row(ctl(nop(), 1, 1, 1, 0), E0);
    row(nop(), E0);
    row(ins(5, 0, 1, 0, 0, 0), E0);
    row(ins(6, 5, 1, 0, 1, 0), FWD ? E0 : STL);
    row(ctl(ins(6, 5, 1, 0, 1, 0), 0, 0, 0, 0), E0);
    row(ins(6, 5, 1, 0, 1, 0), E0);
    drain();
    foreach (st_tab[i]) begin
      apply(st_tab[i]); exp_q.push_back(ex_tab[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL reset_abort[%0d] got=%b want=%b", i, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(ctl(nop(), 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw();
    test_load_use();
    test_x0_unused();
    test_jump();
    test_mem_hold();
    test_trap();
    test_trap_hold();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It owns the decode stage's `stall_flg` and the bubble/flush/hold controls. A scoreboard tracks destination registers still in flight between decode and writeback, and the controller stalls decode on read-after-write hazards, flushes on taken jumps, freezes the back end while memory is busy, and parks the front end during ecall trap entry.

## Interface
- `PIPE_DEPTH`, 3: stages between decode issue and register-file write (EX, MEM, WB).
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs1_addr` in 5, `id_rs1_used` in 1: rs1 index; rs1 is actually read.
- `id_rs2_addr` in 5, `id_rs2_used` in 1: rs2 index; rs2 is actually read.
- `id_rd_addr` in 5, `id_rf_wen` in 1: destination index and write enable.
- `id_is_load` in 1: decode instruction is LB/LBU/LH/LHU/LW.
- `id_is_ecall` in 1: decode instruction is ECALL.
- `ex_jmp_taken` in 1: execute resolved a jump or taken branch this cycle.
- `mem_busy` in 1: memory stage is waiting on memory.
- `trap_done` in 1: trap redirect is complete, one-cycle pulse.
- `stall_flg` out 1: freeze fetch and decode; decode replays its saved instruction.
- `id_bubble` out 1: replace the decode→execute payload with a NOP this cycle.
- `flush` out 1: kill the fetch/decode contents.
- `pipe_hold` out 1: freeze execute, memory and writeback.
- `state` out 2: debug view of the FSM (RUN=0, MEMWAIT=1, TRAP=2).

## Operation
- **Scoreboard:** `PIPE_DEPTH` slots, each {valid, rd, load}. Slot 0 is the youngest.
- **Scoreboard shift:** slots shift toward the oldest every cycle `pipe_hold`=0.
- **Slot 0 load:** slot 0 loads {1, `id_rd_addr`, `id_is_load`} when an instruction issues; otherwise slot 0 gets a bubble.
- **Issue condition:** `id_valid` & !`stall_flg` & !`flush` & `id_rf_wen` & `id_rd_addr`≠0.
- **Hazard:** a used rs≠0 matches the rd of any valid slot. `hazard` = `id_valid` & match. x0 never hazards.
- **RUN:**
  - `mem_busy` → `pipe_hold`=1, `stall_flg`=1, go to MEMWAIT.
  - Else `ex_jmp_taken` → `flush`=1 and `id_bubble`=1; the hazard is ignored that cycle.
  - Else `hazard` → `stall_flg`=1 and `id_bubble`=1.
  - Else if `id_is_ecall` & `id_valid` → issue the ecall, then go to TRAP.
- **MEMWAIT:** hold all outputs as described for MEMWAIT. Return to RUN on the first cycle `mem_busy`=0; that cycle is evaluated as RUN.
- **TRAP:** `stall_flg`=1 and `id_bubble`=1; the scoreboard keeps draining. On `trap_done`: `flush`=1 for that cycle, then go to RUN.
- **Priority:** `mem_busy` > `ex_jmp_taken` > `hazard` > ecall.
- **Jump while held:** `ex_jmp_taken` is ignored while `pipe_hold`=1. Execute re-presents it after the hold releases.
- **Simultaneous TRAP events:** in TRAP, `mem_busy` still forces `pipe_hold`. `trap_done` arriving with `mem_busy`=1 is latched and acted on when the hold releases.

## Timing
- Outputs are combinational from the registered state, the scoreboard and the current inputs. A hazard stalls in the same cycle it is presented.
- A RAW match in slot k (0 = youngest) stalls for `PIPE_DEPTH`−k cycles. The instruction issues on the cycle after the matching slot retires.
- `flush` is exactly one cycle per taken jump or per `trap_done`.
- **Reset:**
  - While `rst_n`=0: state=RUN, all slots invalid, the latched `trap_done` is cleared.
  - While `rst_n`=0, every output is 0.
  - Reset asserted mid-stall or mid-TRAP aborts immediately. The first cycle after release is RUN with an empty scoreboard.

## Configuration
- `HAZARD_FWD_EN` defined: execute/memory forwarding exists.
  - Only a load-use match stalls: a match against slot 0 with load=1.
  - That stall lasts exactly 1 cycle. All other matches are forwarded and cause no stall.
- `HAZARD_FWD_EN` undefined: the full scoreboard interlock described under Operation applies.

## Structure
- **Shared core package:**
  - the FSM state encoding: `HZ_RUN`, `HZ_MEMWAIT`, `HZ_TRAP`;
  - the scoreboard slot typedef {valid, rd[4:0], load};
  - `PIPE_DEPTH_DEFAULT`.
- **Sub-module `hazard_scoreboard`:** owns the shift register and the rs1/rs2 match comparators, and outputs a per-slot match vector. The FSM and output logic stay in `hazard_ctrl`.

## Test plan
- **RAW stall:** `addi x5` issues, then `add x6,x5,x0` is presented. Required: `stall_flg`=`id_bubble`=1 for 3 cycles, issue on cycle 4. With `HAZARD_FWD_EN`: no stall.
- **Load-use:** `lw x7`, then `sub x8,x7,x1`. Required: 3-cycle stall. With `HAZARD_FWD_EN`: exactly 1-cycle stall.
- **x0 / unused operand:** `addi x0`, then `add x1,x0,x0`; also `lui x2`, then `jal` using rs fields = 2 with used=0. Required: no stall in either case.
- **Jump priority:** `ex_jmp_taken`=1 together with a pending hazard. Required: `flush`=1 for 1 cycle, `stall_flg`=0, slot 0 invalid next cycle.
- **Memory hold:** `mem_busy`=1 for 4 cycles with `ex_jmp_taken`=1. Required:
  - `pipe_hold`=1 and scoreboard frozen for 4 cycles;
  - no flush during the hold; `flush` on the first cycle `mem_busy`=0, while execute still presents the jump.
- **Trap and reset:**
  - ecall issues, then `trap_done` after 5 cycles. Required: TRAP for 5 cycles, then `flush`=1, then RUN.
  - Repeat with `rst_n` pulsed low in cycle 2. Required: all outputs 0 during reset, state=RUN after release.
